shift_sched: RTL and testbench
==============================

# shift_sched

Command scheduler for the 4-bit bidirectional shift-register datapath. Two requesters submit load, shift and rotate commands over valid/ready handshakes. A round-robin arbiter grants one command at a time. An FSM drives the register's load, direction, serial-in and enable controls for the required number of cycles, then returns the resulting register contents on a response channel tagged with the requester ID.

## Interface
Parameters:
- WIDTH, 4, shift-register width
- CNT_W, 3, shift-count field width

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-high (asserted when 1)
- req0_valid / req1_valid  in  1  command present
- req0_ready / req1_ready  out  1  command accepted this cycle when valid&ready
- req0_op / req1_op  in  3  0 LOAD, 1 SHR, 2 SHL, 3 ROTR, 4 ROTL, 5-7 illegal
- req0_cnt / req1_cnt  in  CNT_W  number of shift steps; ignored for LOAD
- req0_data / req1_data  in  WIDTH  parallel value for LOAD
- req0_sin / req1_sin  in  1  serial-in bit for SHR/SHL
- sr_en  out  1  register updates on this edge when 1, holds when 0
- sr_load  out  1  parallel load (valid with sr_en)
- sr_dir  out  1  0 = shift right (sin enters MSB), 1 = shift left (sin enters LSB)
- sr_sin  out  1  serial-in to register
- sr_pdata  out  WIDTH  parallel load value
- sr_q  in  WIDTH  current register contents
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed
- rsp_id  out  1  requester index
- rsp_err  out  1  illegal opcode
- rsp_data  out  WIDTH  register contents after the command
- busy  out  1  FSM not in IDLE

## Operation
- States:
  - IDLE: ready to the granted requester only. Accept at valid&ready and latch op, cnt, data, sin and ID.
  - IDLE → EXEC when the latched op is legal and the step count is nonzero. Step count: LOAD = 1; otherwise cnt.
  - IDLE → RESP on an illegal op (rsp_err = 1) or on a shift/rotate with cnt = 0.
  - EXEC: sr_en = 1 every cycle. Remaining-step counter decrements each cycle. Go to RESP after the last step.
  - RESP: rsp_valid = 1; rsp_data = sr_q (post-operation value); rsp_id and rsp_err held stable. Go to IDLE on rsp_ready.
- Control per op in EXEC:
  - LOAD: sr_load = 1, sr_pdata = data.
  - SHR/SHL: sr_dir = 0/1, sr_sin = latched sin.
  - ROTR: sr_dir = 0, sr_sin = sr_q[0].
  - ROTL: sr_dir = 1, sr_sin = sr_q[WIDTH-1].
  - Outside EXEC: sr_en = sr_load = 0.
- Arbitration: 2-way round-robin. The pointer moves past the winner only on an accepted handshake. After reset req0 has priority. A lone valid requester wins regardless of the pointer.
- cnt > WIDTH is legal and executes exactly cnt steps (e.g. ROTR by 5 = ROTR by 1).
- Reset values: state IDLE, all sr_* outputs 0, rsp_valid/rsp_err/rsp_id/rsp_data 0, busy 0, arbiter pointer favours req0.

## Timing
- Accept on edge T. EXEC occupies cycles T+1..T+n, with register updates on edges T+2..T+n+1. rsp_valid rises in cycle T+n+1.
- Latency from accept to rsp_valid:
  - n+1 cycles for legal commands (LOAD = 2).
  - 1 cycle for an illegal op or cnt = 0.
- One command in flight. Both ready signals are 0 from accept until the RESP handshake completes.
- Back-to-back: a new accept is possible in the cycle after the RESP handshake.
- The ready signals are combinational from state, grant and valid. They must not depend on rsp_ready.
- Reset asserted mid-command aborts it: no response is issued, and sr_en drops immediately (asynchronously). The register contents are left to the datapath's own reset.

## Structure
- Package shift_sched_pkg contains:
  - op_t enum (LOAD, SHR, SHL, ROTR, ROTL)
  - state_t enum (IDLE, EXEC, RESP)
  - WIDTH default
  - an is_legal_op function
- Sub-module shift_rr_arb: 2-requester round-robin arbiter with a grant-accept input.
- The shift register itself stays external; only sr_q is fed back.

## Test plan
- Reset, then req0 LOAD data=4'b1010: sr_en/sr_load high for 1 cycle; rsp_valid 2 cycles after accept with rsp_data=1010, rsp_id=0, rsp_err=0.
- After loading 1010, req1 SHL cnt=2 sin=1: rsp_data=1011, rsp_id=1, rsp_valid 3 cycles after accept.
- After loading 1001, ROTR cnt=5: rsp_data=1100.
- req0 and req1 both valid continuously with LOAD 0001 / LOAD 0010: grants alternate 0,1,0,1 and responses carry alternating IDs.
- Illegal op=6: sr_en never asserts; rsp_err=1 one cycle after accept. Hold rsp_ready=0 for 3 cycles: the response stays stable and both ready signals stay 0.
- Assert rst_n mid-EXEC of SHR cnt=4: sr_en and rsp_valid drop to 0 asynchronously; after release, an idle requester is accepted normally with req0 priority.

Source files
------------

// File: rtl/shift_sched_pkg.sv
// rtl/shift_sched_pkg.sv - Shared types, defaults and opcode helper for the shift-register scheduler
package shift_sched_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_CNT_W = 3;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_SHR  = 3'd1,
        OP_SHL  = 3'd2,
        OP_ROTR = 3'd3,
        OP_ROTL = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return op <= 3'd4;
    endfunction

endpackage

// File: rtl/shift_rr_arb.sv
// rtl/shift_rr_arb.sv - Two-requester round-robin arbiter; pointer advances only on an accepted grant
module shift_rr_arb (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic ptr_q;
    logic ptr_d;

    // ptr_q = 1 means req1 wins a tie; a lone requester always wins
    always_comb begin
        if (req == 2'b11) begin
            grant = ptr_q ? 2'b10 : 2'b01;
        end else begin
            grant = req;
        end
        ptr_d = ptr_q;
        if (accept) begin
            ptr_d = grant[0];
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/shift_sched.sv
// rtl/shift_sched.sv - Arbitrates two command streams and sequences the external shift register
module shift_sched
    import shift_sched_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [CNT_W-1:0] req0_cnt,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_sin,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [CNT_W-1:0] req1_cnt,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_sin,
    output logic             sr_en,
    output logic             sr_load,
    output logic             sr_dir,
    output logic             sr_sin,
    output logic [WIDTH-1:0] sr_pdata,
    input  logic [WIDTH-1:0] sr_q,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic             rsp_err,
    output logic [WIDTH-1:0] rsp_data,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             sin_q, sin_d;
    logic             id_q, id_d;
    logic             err_q, err_d;

    logic [1:0]       grant;
    logic             accept;
    logic             sel_id;
    logic [2:0]       sel_op;
    logic [CNT_W-1:0] sel_cnt;
    logic [WIDTH-1:0] sel_data;
    logic             sel_sin;

    shift_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant)
    );

    assign accept   = (state_q == ST_IDLE) && (grant != 2'b00);
    assign sel_id   = grant[1];
    assign sel_op   = sel_id ? req1_op   : req0_op;
    assign sel_cnt  = sel_id ? req1_cnt  : req0_cnt;
    assign sel_data = sel_id ? req1_data : req0_data;
    assign sel_sin  = sel_id ? req1_sin  : req0_sin;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            op_q   <= 3'd0;
            cnt_q  <= '0;
            data_q <= '0;
            sin_q  <= 1'b0;
            id_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            data_q <= data_d;
            sin_q  <= sin_d;
            id_q   <= id_d;
            err_q  <= err_d;
        end
    end

    // cnt_q holds the steps still to run; a zero count skips EXEC entirely
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        sin_d   = sin_q;
        id_d    = id_q;
        err_d   = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = sel_op;
                    data_d  = sel_data;
                    sin_d   = sel_sin;
                    id_d    = sel_id;
                    err_d   = !is_legal_op(sel_op);
                    cnt_d   = (sel_op == OP_LOAD) ? CNT_W'(1) : sel_cnt;
                    state_d = (!err_d && (cnt_d != '0)) ? ST_EXEC : ST_RESP;
                end
            end
            ST_EXEC: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sr_en      = 1'b0;
        sr_load    = 1'b0;
        sr_dir     = 1'b0;
        sr_sin     = 1'b0;
        sr_pdata   = '0;
        rsp_valid  = 1'b0;
        rsp_id     = 1'b0;
        rsp_err    = 1'b0;
        rsp_data   = '0;
        busy       = (state_q != ST_IDLE);
        req0_ready = (state_q == ST_IDLE) && grant[0];
        req1_ready = (state_q == ST_IDLE) && grant[1];
        case (state_q)
            ST_EXEC: begin
                sr_en = 1'b1;
                case (op_q)
                    OP_LOAD: begin
                        sr_load  = 1'b1;
                        sr_pdata = data_q;
                    end
                    OP_SHR: sr_sin = sin_q;
                    OP_SHL: begin
                        sr_dir = 1'b1;
                        sr_sin = sin_q;
                    end
                    OP_ROTR: sr_sin = sr_q[0];
                    OP_ROTL: begin
                        sr_dir = 1'b1;
                        sr_sin = sr_q[WIDTH-1];
                    end
                    default: sr_sin = 1'b0;
                endcase
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                rsp_id    = id_q;
                rsp_err   = err_q;
                rsp_data  = sr_q;
            end
            default: busy = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_shift_sched.sv
// tb/tb_shift_sched.sv - Directed bench with an external register model and a cycle-level reference checker
module tb_shift_sched;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic [2:0] req0_op = 3'd0, req1_op = 3'd0;
    logic [2:0] req0_cnt = 3'd0, req1_cnt = 3'd0;
    logic [3:0] req0_data = 4'd0, req1_data = 4'd0;
    logic       req0_sin = 1'b0, req1_sin = 1'b0;
    logic       req0_ready, req1_ready;
    logic       sr_en, sr_load, sr_dir, sr_sin;
    logic [3:0] sr_pdata;
    logic [3:0] sr_q = 4'd0;
    logic       rsp_valid, rsp_id, rsp_err;
    logic       rsp_ready = 1'b0;
    logic [3:0] rsp_data;
    logic       busy;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    shift_sched #(.WIDTH(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_op    (req0_op),
        .req0_cnt   (req0_cnt),
        .req0_data  (req0_data),
        .req0_sin   (req0_sin),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_op    (req1_op),
        .req1_cnt   (req1_cnt),
        .req1_data  (req1_data),
        .req1_sin   (req1_sin),
        .sr_en      (sr_en),
        .sr_load    (sr_load),
        .sr_dir     (sr_dir),
        .sr_sin     (sr_sin),
        .sr_pdata   (sr_pdata),
        .sr_q       (sr_q),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // The shift register the scheduler drives; it has no reset of its own here
    always @(posedge clk) begin
        if (sr_en) begin
            if (sr_load)     sr_q <= sr_pdata;
            else if (sr_dir) sr_q <= {sr_q[2:0], sr_sin};
            else             sr_q <= {sr_sin, sr_q[3:1]};
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] model_apply(input logic [3:0] r, input int op, input int cnt,
                                               input logic [3:0] d, input logic s);
        int v;
        int k;
        v = int'(r);
        k = cnt % 4;
        case (op)
            0: v = int'(d);
            1: for (int i = 0; i < cnt; i++) v = (v >> 1) | (s ? 8 : 0);
            2: for (int i = 0; i < cnt; i++) v = ((v << 1) & 15) | (s ? 1 : 0);
            3: v = ((v >> k) | (v << (4 - k))) & 15;
            4: v = ((v << k) | (v >> (4 - k))) & 15;
            default: v = int'(r);
        endcase
        return v[3:0];
    endfunction

    logic       inf = 1'b0;
    logic       fav0 = 1'b1;
    int         acc_c = 0;
    int         e_n = 0;
    int         e_op = 0;
    logic       e_id = 1'b0, e_err = 1'b0, e_sin = 1'b0;
    logic [3:0] e_data = 4'd0, e_pdata = 4'd0;
    logic [3:0] model_reg = 4'd0;
    logic       exp_en, exp_rv, exp_sin, e0, e1, w;
    int         w_op, w_cnt;

    always @(negedge clk) begin
        if (rst_n) begin
            chk("rst_sr", {sr_en, sr_load, sr_dir, sr_sin, sr_pdata}, 32'd0);
            chk("rst_rsp", {rsp_valid, rsp_err, rsp_id, rsp_data, busy}, 32'd0);
            inf = 1'b0;
            fav0 = 1'b1;
            model_reg = sr_q;
        end else if (inf) begin
            exp_en = (cyc >= acc_c + 1) && (cyc <= acc_c + e_n);
            exp_rv = (cyc >= acc_c + e_n + 1);
            chk("sr_en", sr_en, exp_en);
            chk("rsp_valid", rsp_valid, exp_rv);
            chk("busy_ready", {busy, req1_ready, req0_ready}, 3'b100);
            if (exp_en) begin
                exp_sin = (e_op == 3) ? sr_q[0] : (e_op == 4) ? sr_q[3] : e_sin;
                chk("sr_load", sr_load, e_op == 0);
                if (e_op == 0) chk("sr_pdata", sr_pdata, e_pdata);
                else chk("sr_dir_sin", {sr_dir, sr_sin}, {(e_op == 2 || e_op == 4), exp_sin});
            end else begin
                chk("sr_load_off", sr_load, 1'b0);
            end
            if (exp_rv) begin
                chk("rsp_fields", {rsp_id, rsp_err, rsp_data}, {e_id, e_err, e_data});
                if (rsp_ready && rsp_valid) inf = 1'b0;
            end
        end else begin
            e0 = req0_valid && (!req1_valid || fav0);
            e1 = req1_valid && (!req0_valid || !fav0);
            chk("idle_ready", {req1_ready, req0_ready}, {e1, e0});
            chk("idle_out", {busy, sr_en, rsp_valid}, 32'd0);
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                w = req1_valid && req1_ready;
                fav0 = w;
                w_op = int'(w ? req1_op : req0_op);
                w_cnt = int'(w ? req1_cnt : req0_cnt);
                e_id = w;
                e_op = w_op;
                e_sin = w ? req1_sin : req0_sin;
                e_pdata = w ? req1_data : req0_data;
                e_err = (w_op > 4);
                e_n = e_err ? 0 : (w_op == 0) ? 1 : w_cnt;
                e_data = e_err ? model_reg : model_apply(model_reg, w_op, w_cnt, e_pdata, e_sin);
                model_reg = e_data;
                acc_c = cyc;
                inf = 1'b1;
            end
        end
    end

    task automatic send(input int id, input int op, input int cnt, input int data, input int sin);
        logic got;
        if (id == 0) begin
            req0_op = op[2:0]; req0_cnt = cnt[2:0]; req0_data = data[3:0]; req0_sin = sin[0];
            req0_valid = 1'b1;
        end else begin
            req1_op = op[2:0]; req1_cnt = cnt[2:0]; req1_data = data[3:0]; req1_sin = sin[0];
            req1_valid = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if ((id == 0) ? req0_ready : req1_ready) got = 1'b1;
        end
        if (!got) chk("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (id == 0) req0_valid = 1'b0;
        else req1_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int exp_lat, input logic exp_id,
                            input logic exp_err, input logic [3:0] exp_data, input logic ack);
        int k;
        k = 0;
        for (int i = 1; i <= 20 && k == 0; i++) begin
            @(negedge clk);
            if (rsp_valid) k = i;
        end
        chk({name, "_lat"}, k, exp_lat);
        chk({name, "_rsp"}, {rsp_id, rsp_err, rsp_data}, {exp_id, exp_err, exp_data});
        if (ack) begin
            @(posedge clk); #1 rsp_ready = 1'b1;
            @(posedge clk); #1 rsp_ready = 1'b0;
        end
    endtask

    initial begin
        logic [3:0] ids;
        int n;
        logic got;
        ids = 4'b1111;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;

        send(0, 0, 0, 4'b1010, 0);
        wait_rsp("load1010", 2, 1'b0, 1'b0, 4'b1010, 1'b1);
        send(1, 2, 2, 0, 1);
        wait_rsp("shl2", 3, 1'b1, 1'b0, 4'b1011, 1'b1);
        send(0, 0, 0, 4'b1001, 0);
        wait_rsp("load1001", 2, 1'b0, 1'b0, 4'b1001, 1'b1);
        send(1, 3, 5, 0, 0);
        wait_rsp("rotr5", 6, 1'b1, 1'b0, 4'b1100, 1'b1);

        // Both requesters held valid: grants must alternate
        req0_op = 3'd0; req0_data = 4'b0001; req0_valid = 1'b1;
        req1_op = 3'd0; req1_data = 4'b0010; req1_valid = 1'b1;
        rsp_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 60 && n < 4; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                ids[3-n] = rsp_id;
                chk("alt_data", rsp_data, rsp_id ? 4'b0010 : 4'b0001);
                n++;
            end
        end
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
        chk("alt_ids", ids, 4'b0101);

        send(0, 4, 1, 0, 0);
        wait_rsp("rotl1", 2, 1'b0, 1'b0, 4'b0100, 1'b1);
        send(1, 4, 0, 0, 0);
        wait_rsp("rotl0", 1, 1'b1, 1'b0, 4'b0100, 1'b1);

        send(0, 6, 3, 4'hF, 1);
        wait_rsp("illegal", 1, 1'b0, 1'b1, 4'b0100, 1'b0);
        @(posedge clk);
        #1 req1_op = 3'd0; req1_data = 4'b1111; req1_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_rsp", {rsp_valid, rsp_id, rsp_err, rsp_data, req1_ready, req0_ready},
                {1'b1, 1'b0, 1'b1, 4'b0100, 2'b00});
        end
        @(posedge clk);
        #1 req1_valid = 1'b0; rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;

        // Abort a long shift with reset part-way through
        send(1, 1, 4, 0, 1);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            if (sr_en) got = 1'b1;
        end
        chk("shr_started", got, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("async_drop", {sr_en, rsp_valid, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        req0_op = 3'd0; req0_data = 4'b0101; req0_valid = 1'b1;
        req1_op = 3'd0; req1_data = 4'b0110; req1_valid = 1'b1;
        @(negedge clk);
        chk("post_rst_prio", {req1_ready, req0_ready}, 2'b01);
        @(posedge clk);
        #1 req0_valid = 1'b0; req1_valid = 1'b0;
        wait_rsp("post_rst_load", 2, 1'b0, 1'b0, 4'b0101, 1'b1);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
